// File: rtl/peg_board_engine.sv
// Peg-solitaire board engine: move legality check, circular undo history and a
// fixed-latency full-board scan that decides game_over after every board change.
module peg_board_engine #(
    parameter int unsigned BOARD_WIDTH = 7,
    parameter int unsigned ARM         = 2,
    parameter int unsigned HIST_DEPTH  = 16,
    localparam int unsigned CW         = $clog2(BOARD_WIDTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          move_valid,
    output logic          move_ready,
    input  logic [CW-1:0] move_x,
    input  logic [CW-1:0] move_y,
    input  logic [1:0]    move_dir,
    input  logic          undo_valid,
    input  logic          new_game,
    output logic          resp_valid,
    output logic          resp_legal,
    output logic [7:0]    peg_count,
    output logic          game_over,
    input  logic [CW-1:0] rd_x,
    input  logic [CW-1:0] rd_y,
    output logic          rd_peg
);
    localparam int unsigned EW        = CW + 1;
    localparam int unsigned NC        = BOARD_WIDTH * BOARD_WIDTH;
    localparam int unsigned IW        = $clog2(NC);
    localparam int unsigned HW        = $clog2(HIST_DEPTH);
    localparam int unsigned HEW       = 2 * CW + 2;
    localparam int unsigned CTR       = (BOARD_WIDTH - 1) / 2;
    localparam int unsigned INIT_PEGS = NC - 4 * ARM * ARM - 1;

    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_APPLY, S_SCAN, S_RESP} state_t;
    typedef enum logic [1:0] {OP_MOVE, OP_UNDO, OP_NEW} op_t;

    // Coordinates are one bit wider than CW so that neighbour offsets never wrap.
    function automatic logic cell_exists(input logic [EW-1:0] x, input logic [EW-1:0] y);
        logic x_arm;
        logic y_arm;
        x_arm = (32'(x) < ARM) || (32'(x) >= BOARD_WIDTH - ARM);
        y_arm = (32'(y) < ARM) || (32'(y) >= BOARD_WIDTH - ARM);
        return (32'(x) < BOARD_WIDTH) && (32'(y) < BOARD_WIDTH) && !(x_arm && y_arm);
    endfunction

    function automatic logic [IW-1:0] cell_idx(input logic [EW-1:0] x, input logic [EW-1:0] y);
        return IW'(32'(y) * BOARD_WIDTH + 32'(x));
    endfunction

    function automatic logic peg_at(input logic [NC-1:0] b, input logic [EW-1:0] x,
                                    input logic [EW-1:0] y);
        logic p;
        p = 1'b0;
        if (cell_exists(x, y)) p = b[cell_idx(x, y)];
        return p;
    endfunction

    function automatic logic [2*EW-1:0] step(input logic [EW-1:0] x, input logic [EW-1:0] y,
                                              input logic [1:0] dir, input logic [EW-1:0] k);
        logic [EW-1:0] nx;
        logic [EW-1:0] ny;
        nx = x;
        ny = y;
        case (dir)
            2'b00:   nx = x - k;
            2'b01:   nx = x + k;
            2'b10:   ny = y - k;
            default: ny = y + k;
        endcase
        return {nx, ny};
    endfunction

    function automatic logic move_legal(input logic [NC-1:0] b, input logic [EW-1:0] x,
                                        input logic [EW-1:0] y, input logic [1:0] dir);
        logic [EW-1:0] ox, oy, tx, ty;
        {ox, oy} = step(x, y, dir, EW'(1));
        {tx, ty} = step(x, y, dir, EW'(2));
        return peg_at(b, x, y) && peg_at(b, ox, oy) && cell_exists(tx, ty) && !peg_at(b, tx, ty);
    endfunction

    function automatic logic [NC-1:0] init_board();
        logic [NC-1:0] b;
        b = '0;
        for (int unsigned yy = 0; yy < BOARD_WIDTH; yy++)
            for (int unsigned xx = 0; xx < BOARD_WIDTH; xx++)
                b[IW'(yy * BOARD_WIDTH + xx)] = cell_exists(EW'(xx), EW'(yy)) && !(xx == CTR && yy == CTR);
        return b;
    endfunction

    localparam logic [NC-1:0] INIT_BOARD = init_board();

    state_t          state, state_next;
    op_t             op;
    logic [EW-1:0]   cmd_x, cmd_y;
    logic [1:0]      cmd_dir;
    logic            ok_q;
    logic [NC-1:0]   board;
    logic [HEW-1:0]  hist [HIST_DEPTH];
    logic [HW-1:0]   hist_wp;
    logic [HW:0]     hist_cnt;
    logic [CW-1:0]   scan_x, scan_y;
    logic            found;
    logic            cmd_legal, scan_hit, scan_last, hist_empty;
    logic [HEW-1:0]  hist_top;
    logic [EW-1:0]   over_x, over_y, to_x, to_y;
    logic [IW-1:0]   from_i, over_i, to_i;

    // Legality of the captured command and of the cell under the scan cursor.
    always_comb begin
        cmd_legal = move_legal(board, cmd_x, cmd_y, cmd_dir);
        scan_hit  = 1'b0;
        for (int d = 0; d < 4; d++)
            scan_hit = scan_hit | move_legal(board, {1'b0, scan_x}, {1'b0, scan_y}, 2'(d));
        {over_x, over_y} = step(cmd_x, cmd_y, cmd_dir, EW'(1));
        {to_x, to_y}     = step(cmd_x, cmd_y, cmd_dir, EW'(2));
        from_i = cell_idx(cmd_x, cmd_y);
        over_i = cell_idx(over_x, over_y);
        to_i   = cell_idx(to_x, to_y);
    end

    assign scan_last  = (scan_x == CW'(BOARD_WIDTH - 1)) && (scan_y == CW'(BOARD_WIDTH - 1));
    assign hist_empty = (hist_cnt == '0);
    assign hist_top   = hist[hist_wp - HW'(1)];
    assign rd_peg     = peg_at(board, {1'b0, rd_x}, {1'b0, rd_y});

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    // Next-state logic; new_game beats undo beats move.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (new_game)        state_next = S_APPLY;
                else if (undo_valid) state_next = hist_empty ? S_CHECK : S_APPLY;
                else if (move_valid) state_next = S_CHECK;
            end
            S_CHECK: state_next = (op == OP_MOVE && cmd_legal) ? S_APPLY : S_RESP;
            S_APPLY: state_next = S_SCAN;
            S_SCAN:  if (scan_last) state_next = S_RESP;
            S_RESP:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Handshake and response outputs decoded from the state register.
    always_comb begin
        move_ready = 1'b0;
        resp_valid = 1'b0;
        resp_legal = 1'b0;
        case (state)
            S_IDLE: move_ready = 1'b1;
            S_RESP: begin
                resp_valid = 1'b1;
                resp_legal = ok_q;
            end
            default: ;
        endcase
    end

    // Command capture, board/history update and the game-over scan.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op        <= OP_MOVE;
            cmd_x     <= '0;
            cmd_y     <= '0;
            cmd_dir   <= '0;
            ok_q      <= 1'b0;
            board     <= INIT_BOARD;
            peg_count <= 8'(INIT_PEGS);
            hist_wp   <= '0;
            hist_cnt  <= '0;
            scan_x    <= '0;
            scan_y    <= '0;
            found     <= 1'b0;
            game_over <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (new_game) begin
                        op <= OP_NEW;
                    end else if (undo_valid) begin
                        op      <= OP_UNDO;
                        cmd_x   <= {1'b0, hist_top[HEW-1 -: CW]};
                        cmd_y   <= {1'b0, hist_top[CW+1 -: CW]};
                        cmd_dir <= hist_top[1:0];
                    end else if (move_valid) begin
                        op      <= OP_MOVE;
                        cmd_x   <= {1'b0, move_x};
                        cmd_y   <= {1'b0, move_y};
                        cmd_dir <= move_dir;
                    end
                end
                S_CHECK: ok_q <= (op == OP_MOVE) && cmd_legal;
                S_APPLY: begin
                    ok_q   <= 1'b1;
                    scan_x <= '0;
                    scan_y <= '0;
                    found  <= 1'b0;
                    case (op)
                        OP_MOVE: begin
                            board[from_i] <= 1'b0;
                            board[over_i] <= 1'b0;
                            board[to_i]   <= 1'b1;
                            peg_count     <= peg_count - 8'd1;
                            hist_wp       <= hist_wp + HW'(1);
                            if (hist_cnt != (HW+1)'(HIST_DEPTH)) hist_cnt <= hist_cnt + (HW+1)'(1);
                        end
                        OP_UNDO: begin
                            board[from_i] <= 1'b1;
                            board[over_i] <= 1'b1;
                            board[to_i]   <= 1'b0;
                            peg_count     <= peg_count + 8'd1;
                            hist_wp       <= hist_wp - HW'(1);
                            hist_cnt      <= hist_cnt - (HW+1)'(1);
                        end
                        default: begin
                            board     <= INIT_BOARD;
                            peg_count <= 8'(INIT_PEGS);
                            hist_wp   <= '0;
                            hist_cnt  <= '0;
                        end
                    endcase
                end
                S_SCAN: begin
                    found <= found | scan_hit;
                    if (scan_x == CW'(BOARD_WIDTH - 1)) begin
                        scan_x <= '0;
                        scan_y <= scan_y + CW'(1);
                    end else begin
                        scan_x <= scan_x + CW'(1);
                    end
                    if (scan_last) game_over <= !(found | scan_hit);
                end
                default: ;
            endcase
        end
    end

    // History storage; a full buffer simply overwrites its oldest slot.
    always_ff @(posedge clk) begin
        if (state == S_APPLY && op == OP_MOVE)
            hist[hist_wp] <= {cmd_x[CW-1:0], cmd_y[CW-1:0], cmd_dir};
    end

endmodule

// File: tb/tb_peg_board_engine.sv
// Bench for peg_board_engine: directed scenarios plus random play, checked
// against a board-level model of the game rules and command latencies.
module tb_peg_board_engine;
    localparam int W     = 7;
    localparam int ARMV  = 2;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       move_valid = 1'b0;
    logic       undo_valid = 1'b0;
    logic       new_game = 1'b0;
    logic [2:0] move_x = '0;
    logic [2:0] move_y = '0;
    logic [1:0] move_dir = '0;
    logic [2:0] rd_x = '0;
    logic [2:0] rd_y = '0;
    logic       move_ready, resp_valid, resp_legal, game_over, rd_peg;
    logic [7:0] peg_count;

    peg_board_engine #(.BOARD_WIDTH(W), .ARM(ARMV), .HIST_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .move_valid(move_valid), .move_ready(move_ready),
        .move_x(move_x), .move_y(move_y), .move_dir(move_dir), .undo_valid(undo_valid),
        .new_game(new_game), .resp_valid(resp_valid), .resp_legal(resp_legal),
        .peg_count(peg_count), .game_over(game_over), .rd_x(rd_x), .rd_y(rd_y), .rd_peg(rd_peg)
    );

    always #5 clk = ~clk;

    // Model state: board as [y][x], peg total, game-over flag, undo stack.
    bit mb [W][W];
    int m_pegs = 0;
    bit m_go = 1'b0;
    int m_hist[$];

    int cyc = 0;
    int resp_cyc = -1;
    bit exp_legal = 1'b0;
    bit chk_en = 1'b0;
    int n_cmp = 0;
    int n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
        end
    endtask

    function automatic bit m_exists(int x, int y);
        bit cx, cy;
        if (x < 0 || y < 0 || x >= W || y >= W) return 1'b0;
        cx = (x < ARMV) || (x >= W - ARMV);
        cy = (y < ARMV) || (y >= W - ARMV);
        return !(cx && cy);
    endfunction

    function automatic bit m_peg(int x, int y);
        if (!m_exists(x, y)) return 1'b0;
        return mb[y][x];
    endfunction

    function automatic int dx_of(int d);
        return (d == 0) ? -1 : ((d == 1) ? 1 : 0);
    endfunction

    function automatic int dy_of(int d);
        return (d == 2) ? -1 : ((d == 3) ? 1 : 0);
    endfunction

    function automatic bit m_legal(int x, int y, int d);
        int ox, oy, tx, ty;
        ox = x + dx_of(d);
        oy = y + dy_of(d);
        tx = x + 2 * dx_of(d);
        ty = y + 2 * dy_of(d);
        return m_peg(x, y) && m_peg(ox, oy) && m_exists(tx, ty) && !m_peg(tx, ty);
    endfunction

    function automatic bit m_any();
        for (int y = 0; y < W; y++)
            for (int x = 0; x < W; x++)
                for (int d = 0; d < 4; d++)
                    if (m_legal(x, y, d)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void m_reset();
        m_pegs = 0;
        for (int y = 0; y < W; y++)
            for (int x = 0; x < W; x++) begin
                mb[y][x] = m_exists(x, y) && !(x == (W - 1) / 2 && y == (W - 1) / 2);
                if (mb[y][x]) m_pegs++;
            end
        m_hist.delete();
    endfunction

    function automatic void m_jump(int x, int y, int d, bit fwd);
        mb[y][x] = !fwd;
        mb[y + dy_of(d)][x + dx_of(d)] = !fwd;
        mb[y + 2 * dy_of(d)][x + 2 * dx_of(d)] = fwd;
        m_pegs += fwd ? -1 : 1;
    endfunction

    function automatic int pick_legal();
        int c[$];
        for (int y = 0; y < W; y++)
            for (int x = 0; x < W; x++)
                for (int d = 0; d < 4; d++)
                    if (m_legal(x, y, d)) c.push_back((x << 5) | (y << 2) | d);
        if (c.size() == 0) return -1;
        return c[$urandom_range(0, c.size() - 1)];
    endfunction

    // Issue one command while idle, update the model, and wait out its latency.
    task automatic do_cmd(input bit ng, input bit un, input bit mv, input int x, input int y, input int d);
        int lat;
        bit lg;
        int e;
        lat = 2;
        lg = 1'b0;
        @(negedge clk);
        new_game = ng;
        undo_valid = un;
        move_valid = mv;
        move_x = 3'(x);
        move_y = 3'(y);
        move_dir = 2'(d);
        #1;
        if (ng) begin
            m_reset();
            m_go = !m_any();
            lat = 2 + W * W;
            lg = 1'b1;
        end else if (un) begin
            if (m_hist.size() != 0) begin
                e = m_hist.pop_back();
                m_jump(e >> 5, (e >> 2) & 7, e & 3, 1'b0);
                m_go = !m_any();
                lat = 2 + W * W;
                lg = 1'b1;
            end
        end else if (mv) begin
            if (m_legal(x, y, d)) begin
                m_jump(x, y, d, 1'b1);
                m_hist.push_back((x << 5) | (y << 2) | d);
                if (m_hist.size() > DEPTH) void'(m_hist.pop_front());
                m_go = !m_any();
                lat = 3 + W * W;
                lg = 1'b1;
            end
        end
        resp_cyc = cyc + lat;
        exp_legal = lg;
        @(negedge clk);
        new_game = 1'b0;
        undo_valid = 1'b0;
        move_valid = 1'b0;
        repeat (lat) @(negedge clk);
    endtask

    task automatic do_legal();
        int v;
        v = pick_legal();
        if (v >= 0) do_cmd(1'b0, 1'b0, 1'b1, v >> 5, (v >> 2) & 7, v & 3);
    endtask

    task automatic rd_lit(input string nm, input int x, input int y, input int exp);
        rd_x = 3'(x);
        rd_y = 3'(y);
        #1;
        chk(nm, rd_peg, exp);
    endtask

    task automatic sweep();
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 8; x++) begin
                rd_x = 3'(x);
                rd_y = 3'(y);
                #1;
                chk("rd_peg", rd_peg, m_peg(x, y));
            end
    endtask

    // Per-cycle comparison of the response pulse, handshake and idle-state outputs.
    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            chk("resp_valid", resp_valid, cyc == resp_cyc);
            if (cyc == resp_cyc) chk("resp_legal", resp_legal, exp_legal);
            chk("move_ready", move_ready, cyc > resp_cyc);
            if (cyc > resp_cyc) begin
                chk("peg_count", peg_count, m_pegs);
                chk("game_over", game_over, m_go);
            end
        end
    end

    initial begin
        int r;
        int v;
        m_reset();
        m_go = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);

        // Reset state pinned by hand.
        chk("reset_pegs", peg_count, 32);
        chk("reset_game_over", game_over, 0);
        chk("reset_ready", move_ready, 1);
        rd_lit("reset_rd_3_3", 3, 3, 0);
        rd_lit("reset_rd_0_0", 0, 0, 0);
        rd_lit("reset_rd_3_0", 3, 0, 1);
        sweep();

        // First legal move: (3,1) DOWN.
        do_cmd(1'b0, 1'b0, 1'b1, 3, 1, 3);
        rd_lit("move_rd_3_1", 3, 1, 0);
        rd_lit("move_rd_3_2", 3, 2, 0);
        rd_lit("move_rd_3_3", 3, 3, 1);
        chk("move_pegs", peg_count, 31);
        chk("move_game_over", game_over, 0);

        // Illegal moves: nonexistent corner cell and out-of-range x.
        do_cmd(1'b0, 1'b0, 1'b1, 0, 0, 1);
        do_cmd(1'b0, 1'b0, 1'b1, 7, 3, 0);
        sweep();

        // Undo back to the initial board, then undo on an empty history.
        do_cmd(1'b0, 1'b1, 1'b0, 0, 0, 0);
        chk("undo_pegs", peg_count, 32);
        rd_lit("undo_rd_3_3", 3, 3, 0);
        rd_lit("undo_rd_3_1", 3, 1, 1);
        do_cmd(1'b0, 1'b1, 1'b0, 0, 0, 0);

        // History wrap: five moves, five undos, only four undos succeed.
        for (int i = 0; i < 5; i++) do_legal();
        chk("hist_moves_pegs", peg_count, 27);
        for (int i = 0; i < 5; i++) do_cmd(1'b0, 1'b1, 1'b0, 0, 0, 0);
        chk("hist_final_pegs", peg_count, 31);
        sweep();

        // All three requests together: only new_game runs.
        do_cmd(1'b1, 1'b1, 1'b1, 3, 1, 3);
        chk("combo_pegs", peg_count, 32);
        rd_lit("combo_rd_3_1", 3, 1, 1);

        // Random commands.
        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 99);
            if (r < 5)
                do_cmd(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3, 1, 3);
            else if (r < 25)
                do_cmd(1'b0, 1'b1, 1'($urandom_range(0, 1)), 3, 1, 3);
            else if (r < 45)
                do_cmd(1'b0, 1'b0, 1'b1, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 3));
            else if (pick_legal() >= 0)
                do_legal();
            else
                do_cmd(1'b0, 1'b0, 1'b1, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 3));
            if (i % 6 == 0) sweep();
        end

        // Play legal moves until the board is stuck.
        do_cmd(1'b1, 1'b0, 1'b0, 0, 0, 0);
        for (int i = 0; i < 32; i++) begin
            if (m_any()) do_legal();
        end
        chk("stuck_game_over", game_over, 1);
        sweep();
        do_cmd(1'b0, 1'b0, 1'b1, 3, 1, 3);
        do_cmd(1'b0, 1'b1, 1'b0, 0, 0, 0);
        sweep();
        do_cmd(1'b1, 1'b0, 1'b0, 0, 0, 0);
        chk("restart_game_over", game_over, 0);

        // Reset in the middle of a legal move: no response, initial board.
        v = pick_legal();
        @(negedge clk);
        move_valid = 1'b1;
        move_x = 3'(v >> 5);
        move_y = 3'((v >> 2) & 7);
        move_dir = 2'(v & 3);
        #1;
        chk_en = 1'b0;
        @(negedge clk);
        move_valid = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        m_reset();
        m_go = 1'b0;
        resp_cyc = -1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk_en = 1'b1;
        repeat (60) @(negedge clk);
        chk("midreset_pegs", peg_count, 32);
        sweep();
        do_cmd(1'b0, 1'b1, 1'b0, 0, 0, 0);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
